// File: rtl/tb_uart.sv
// 8N1 UART used as a bench-side companion to a device under test.
// TX is a level-request transmitter with a done/clear handshake; RX is a mid-bit sampler.
module tb_uart #(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_clear_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_done;
  logic          tx_bit_end;
  logic          tx_go;

  assign tx_bit_end = (tx_cnt == LAST);
  assign tx_go      = (tx_state == TX_IDLE) && tx_start && !tx_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_go) tx_next = TX_START;
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    ser_tx       = 1'b1;
    tx_clear_req = 1'b0;
    case (tx_state)
      TX_START: ser_tx = 1'b0;
      TX_DATA:  ser_tx = tx_shift[0];
      TX_STOP:  tx_clear_req = tx_bit_end;
      default:  ser_tx = 1'b1;
    endcase
  end

  // Gated by rst so a requester holding tx_start through reset never sees a stale busy.
  assign tx_busy = !rst && ((tx_start && !tx_done) || (tx_state != TX_IDLE));

  // NOTE: sequential state is written with non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_done  <= 1'b0;
    end else begin
      if (tx_go) begin
        tx_shift <= tx_data;
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end else if (tx_state != TX_IDLE) begin
        tx_cnt <= tx_bit_end ? '0 : tx_cnt + CW'(1);
        if (tx_state == TX_DATA && tx_bit_end) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= tx_bit + 3'd1;
        end
      end
      // Done blocks a held request from re-triggering until the requester lets go.
      if (tx_state == TX_STOP && tx_bit_end) tx_done <= 1'b1;
      else if (!tx_start)                    tx_done <= 1'b0;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t     rx_state, rx_next;
  logic [1:0]    rx_sync;
  logic          rx_s;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_bit_end;
  logic          rx_shift_en, rx_accept, rx_reject;

  // NOTE: synchronizer flops reset to the idle line level so reset release cannot fake a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_sync <= 2'b11;
    else     rx_sync <= {rx_sync[0], ser_rx};
  end

  assign rx_s       = rx_sync[1];
  assign rx_bit_end = (rx_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:      if (!rx_s) rx_next = RX_START;
      RX_START:     if (rx_cnt == HALF) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_bit_end && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:      if (rx_bit_end) rx_next = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_shift_en = (rx_state == RX_DATA) && rx_bit_end;
    rx_accept   = (rx_state == RX_STOP) && rx_bit_end && rx_s;
    rx_reject   = (rx_state == RX_STOP) && rx_bit_end && !rx_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= rx_accept;
      rx_frame_err <= rx_reject;
      if (rx_accept) rx_data <= rx_shift;
      if (rx_shift_en) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end else if (rx_state == RX_IDLE) begin
        rx_bit <= '0;
      end
      // Counter restarts at mid-start so later samples land mid-bit.
      if (rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH)  rx_cnt <= '0;
      else if (rx_state == RX_START && rx_cnt == HALF)      rx_cnt <= '0;
      else if (rx_bit_end)                                  rx_cnt <= '0;
      else                                                  rx_cnt <= rx_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_tb_uart.sv
// Self-checking bench for tb_uart: scoreboarded TX bit stream and RX bytes,
// loopback, glitch/frame-error handling and mid-frame reset.
module tb_tb_uart;

  localparam int CPB   = 347;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       drv_rx = 1'b1;
  logic       loop_en = 1'b0;
  logic       ser_rx, ser_tx, tx_busy, tx_clear_req, rx_valid, rx_frame_err;
  logic [7:0] rx_data;

  int tests = 0;
  int fails = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_clear = 0;

  bit         tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] last_rx = 8'h00;

  always #5 clk = ~clk;

  assign ser_rx = loop_en ? ser_tx : drv_rx;

  tb_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .ser_rx       (ser_rx),
    .ser_tx       (ser_tx),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  always @(negedge clk) begin
    if (rx_valid === 1'b1)     n_valid++;
    if (rx_frame_err === 1'b1) n_err++;
    if (tx_clear_req === 1'b1) n_clear++;
  end

  task automatic push_tx_frame(input logic [7:0] b);
    tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
    tx_q.push_back(1'b1);
  endtask

  // Checks first and last cycle of each of the 10 bits against the queue.
  task automatic check_tx_frame(input string name);
    int t = 0;
    bit exp;
    while (ser_tx !== 1'b0 && t < FRAME) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (ser_tx !== 1'b0) begin
      fails++;
      $display("FAIL %s start: ser_tx=%b after %0d cycles, required 0", name, ser_tx, t);
      tx_q.delete();
      return;
    end
    for (int k = 0; k < 10; k++) begin
      exp = (tx_q.size() > 0) ? tx_q.pop_front() : 1'b1;
      tests++;
      if (ser_tx !== exp) begin
        fails++;
        $display("FAIL %s bit%0d first cycle: ser_tx=%b required %b", name, k, ser_tx, exp);
      end
      repeat (CPB - 1) @(negedge clk);
      tests++;
      if (ser_tx !== exp) begin
        fails++;
        $display("FAIL %s bit%0d last cycle: ser_tx=%b required %b", name, k, ser_tx, exp);
      end
      tests++;
      if (tx_busy !== 1'b1) begin
        fails++;
        $display("FAIL %s busy bit%0d: tx_busy=%b required 1", name, k, tx_busy);
      end
      @(negedge clk);
    end
    tests++;
    if (tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy after frame: tx_busy=%b required 0", name, tx_busy);
    end
  endtask

  task automatic wait_rx_valid(input string name);
    int t = 0;
    logic [7:0] exp;
    while (rx_valid !== 1'b1 && t < 2 * FRAME) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (rx_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s rx_valid timeout: rx_valid=%b after %0d cycles, required 1", name, rx_valid, t);
      return;
    end
    exp = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    tests++;
    if (rx_data !== exp) begin
      fails++;
      $display("FAIL %s rx_data: got %h required %h", name, rx_data, exp);
    end
    last_rx = exp;
    @(negedge clk);
  endtask

  task automatic wait_tx_idle(input string name);
    int t = 0;
    while (tx_busy !== 1'b0 && t < 2 * FRAME) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL %s idle timeout: tx_busy=%b required 0", name, tx_busy);
    end
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
    drv_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drv_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    drv_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    drv_rx = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++; if (ser_tx !== 1'b1)       begin fails++; $display("FAIL reset ser_tx: got %b required 1", ser_tx); end
    tests++; if (tx_busy !== 1'b0)      begin fails++; $display("FAIL reset tx_busy: got %b required 0", tx_busy); end
    tests++; if (tx_clear_req !== 1'b0) begin fails++; $display("FAIL reset tx_clear_req: got %b required 0", tx_clear_req); end
    tests++; if (rx_data !== 8'h00)     begin fails++; $display("FAIL reset rx_data: got %h required 00", rx_data); end
    tests++; if (rx_valid !== 1'b0)     begin fails++; $display("FAIL reset rx_valid: got %b required 0", rx_valid); end
    tests++; if (rx_frame_err !== 1'b0) begin fails++; $display("FAIL reset rx_frame_err: got %b required 0", rx_frame_err); end
    tx_start = 1'b1;
    #1;
    tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL reset busy with request: got %b required 0", tx_busy); end
    tx_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_tx_0f;
    int c0 = n_clear;
    tx_data = 8'h0F;
    tx_start = 1'b1;
    push_tx_frame(8'h0F);
    #1;
    tests++; if (tx_busy !== 1'b1) begin fails++; $display("FAIL tx_0f busy on request: got %b required 1", tx_busy); end
    fork
      check_tx_frame("tx_0f");
      begin
        repeat (CPB * 4) @(negedge clk);
        tx_data = 8'hFF;
      end
    join
    @(negedge clk);
    tests++; if (n_clear - c0 != 1) begin fails++; $display("FAIL tx_0f clear pulses: got %0d required 1", n_clear - c0); end
  endtask

  task automatic test_tx_3d;
    int c0 = n_clear;
    tx_start = 1'b0;
    repeat (3) @(negedge clk);
    tx_data = 8'h3D;
    tx_start = 1'b1;
    push_tx_frame(8'h3D);
    fork
      check_tx_frame("tx_3d");
      begin
        repeat (CPB * 5) @(negedge clk);
        tx_start = 1'b0;
      end
    join
    @(negedge clk);
    tests++; if (n_clear - c0 != 1) begin fails++; $display("FAIL tx_3d clear pulses: got %0d required 1", n_clear - c0); end
  endtask

  task automatic test_hold;
    int c0 = n_clear;
    int lows = 0;
    tx_start = 1'b0;
    repeat (3) @(negedge clk);
    tx_data = 8'h55;
    tx_start = 1'b1;
    push_tx_frame(8'h55);
    check_tx_frame("hold");
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (ser_tx !== 1'b1) lows++;
    end
    tests++; if (lows != 0)           begin fails++; $display("FAIL hold retrigger: %0d low cycles, required 0", lows); end
    tests++; if (n_clear - c0 != 1)   begin fails++; $display("FAIL hold clear pulses: got %0d required 1", n_clear - c0); end
    tests++; if (tx_busy !== 1'b0)    begin fails++; $display("FAIL hold busy: got %b required 0", tx_busy); end
    tx_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_loopback;
    int v0 = n_valid;
    int e0 = n_err;
    logic [7:0] bytes [2] = '{8'h0F, 8'h3D};
    loop_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tx_data = bytes[i];
      tx_start = 1'b1;
      rx_q.push_back(bytes[i]);
      wait_rx_valid("loopback");
      wait_tx_idle("loopback");
      tx_start = 1'b0;
      repeat (4) @(negedge clk);
    end
    loop_en = 1'b0;
    tests++; if (n_valid - v0 != 2) begin fails++; $display("FAIL loopback valid pulses: got %0d required 2", n_valid - v0); end
    tests++; if (n_err != e0)       begin fails++; $display("FAIL loopback frame errors: got %0d required 0", n_err - e0); end
  endtask

  task automatic test_glitch_err;
    int v0 = n_valid;
    int e0 = n_err;
    drv_rx = 1'b0;
    repeat (100) @(negedge clk);
    drv_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    tests++; if (n_valid != v0) begin fails++; $display("FAIL glitch valid: got %0d pulses required 0", n_valid - v0); end
    tests++; if (n_err != e0)   begin fails++; $display("FAIL glitch err: got %0d pulses required 0", n_err - e0); end
    drive_rx_frame(8'hA5, 1'b0);
    repeat (CPB) @(negedge clk);
    tests++; if (n_err - e0 != 1)     begin fails++; $display("FAIL frame_err pulses: got %0d required 1", n_err - e0); end
    tests++; if (n_valid != v0)       begin fails++; $display("FAIL frame_err valid: got %0d pulses required 0", n_valid - v0); end
    tests++; if (rx_data !== last_rx) begin fails++; $display("FAIL frame_err rx_data: got %h required %h", rx_data, last_rx); end
    rx_q.push_back(8'hC3);
    fork
      drive_rx_frame(8'hC3, 1'b1);
      wait_rx_valid("rearm");
    join
    repeat (4) @(negedge clk);
    tests++; if (n_err - e0 != 1) begin fails++; $display("FAIL rearm err: got %0d pulses required 1", n_err - e0); end
  endtask

  task automatic test_reset_mid;
    int c0 = n_clear;
    int v0 = n_valid;
    int e0 = n_err;
    tx_start = 1'b0;
    repeat (3) @(negedge clk);
    tx_data = 8'h69;
    tx_start = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    tests++; if (ser_tx !== 1'b0) begin fails++; $display("FAIL mid pre-reset ser_tx: got %b required 0", ser_tx); end
    rst = 1'b1;
    #1;
    tests++; if (ser_tx !== 1'b1)   begin fails++; $display("FAIL mid reset ser_tx: got %b required 1", ser_tx); end
    tests++; if (tx_busy !== 1'b0)  begin fails++; $display("FAIL mid reset tx_busy: got %b required 0", tx_busy); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL mid reset rx_data: got %h required 00", rx_data); end
    repeat (5) @(negedge clk);
    tests++; if (n_clear != c0) begin fails++; $display("FAIL mid reset clear: got %0d pulses required 0", n_clear - c0); end
    tests++; if (n_valid != v0 || n_err != e0) begin
      fails++; $display("FAIL mid reset rx pulses: valid %0d err %0d required 0 0", n_valid - v0, n_err - e0);
    end
    rst = 1'b0;
    push_tx_frame(8'h69);
    check_tx_frame("after_reset");
    @(negedge clk);
    tests++; if (n_clear - c0 != 1) begin fails++; $display("FAIL after_reset clear pulses: got %0d required 1", n_clear - c0); end
    tx_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_tx_0f();
    test_tx_3d();
    test_hold();
    test_loopback();
    test_glitch_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tb_uart.md
TB_UART -- requirements
Module: tb_uart

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT, default 347, clock cycles per UART bit (115200 baud at 40 MHz).
REQ-002 The ports SHALL be exactly:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  asynchronous reset, active-high.
- ser_rx  input  1  serial line from the device under test, idle high.
- ser_tx  output  1  serial line to the device under test, idle high.
- tx_start  input  1  level transmit request.
- tx_data  input  8  byte to transmit, sampled when a frame starts.
- tx_busy  output  1  high while a request is pending or a frame is on the line.
- tx_clear_req  output  1  one-cycle pulse at frame end; the requester drops tx_start.
- rx_data  output  8  last correctly received byte.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rx_frame_err  output  1  one-cycle pulse when a stop bit reads 0.

Function
REQ-003 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each exactly CLKS_PER_BIT cycles.
REQ-004 The TX state machine SHALL have the states IDLE, START, DATA and STOP, and SHALL hold an internal done flag.
REQ-005 In IDLE with tx_start=1 and done=0 at a rising edge, TX SHALL latch tx_data, enter START, and drive ser_tx low from the next cycle.
REQ-006 START SHALL last CLKS_PER_BIT cycles and then go to DATA; DATA SHALL shift out 8 bits, then go to STOP; STOP SHALL drive 1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-007 On the last cycle of STOP, TX SHALL set done and pulse tx_clear_req for exactly one cycle.
REQ-008 The done flag SHALL clear only when tx_start is sampled 0; while tx_start stays high after completion, no new frame SHALL start.
REQ-009 tx_busy SHALL be combinational: (tx_start AND NOT done) OR (state != IDLE), so a request that is set and then waited on via tx_busy never returns early.
REQ-010 tx_start or tx_data changes during a frame SHALL NOT affect the frame in progress.
REQ-011 ser_rx SHALL pass through a 2-flop synchronizer before use.
REQ-012 The RX state machine SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-013 In IDLE, a synchronized 0 SHALL enter START; at CLKS_PER_BIT/2 (integer division), the line SHALL be rechecked: 1 returns to IDLE (glitch reject), 0 goes to DATA.
REQ-014 DATA SHALL sample each of the 8 bits at CLKS_PER_BIT intervals after the mid-start point, LSB first; the stop bit SHALL be sampled one interval later.
REQ-015 Stop bit = 1: rx_data SHALL be updated and rx_valid pulsed in the same cycle, then RX returns to IDLE.
REQ-016 Stop bit = 0: rx_frame_err SHALL pulse, rx_data SHALL remain unchanged, and RX SHALL enter WAIT_HIGH, rearming only after the line reads 1.
REQ-017 TX and RX SHALL be independent; full-duplex operation SHALL be supported.
REQ-018 The bit counters SHALL be wide enough for CLKS_PER_BIT-1 and SHALL wrap to 0 at each bit boundary.

Reset
REQ-019 While rst=1, the outputs SHALL be: ser_tx=1, tx_busy=0, tx_clear_req=0, rx_data=8'h00, rx_valid=0, rx_frame_err=0; both state machines SHALL be in IDLE, done=0, counters=0, and the synchronizer flops=1.
REQ-020 Reset asserted mid-frame SHALL abort it immediately (asynchronously), with no tx_clear_req, rx_valid or rx_frame_err pulse.

Verification
REQ-021 Set tx_start=1 with tx_data=8'h0F -> ser_tx sequence 0,1,1,1,1,0,0,0,0,1, each bit 347 cycles; tx_busy stays high until frame end; tx_clear_req pulses once.
REQ-022 Drop tx_start, then request 8'h3D -> ser_tx sequence 0,1,0,1,1,1,1,0,0,1; tx_busy falls 3470 cycles after the start edge (+1).
REQ-023 Loop ser_tx to ser_rx and send 8'h0F then 8'h3D -> rx_valid pulses twice; rx_data reads 8'h0F, then 8'h3D; rx_frame_err stays 0.
REQ-024 Hold tx_start high for 3 frame times -> exactly one frame, one tx_clear_req pulse, and tx_busy=0 after the frame.
REQ-025 Drive a 100-cycle low glitch on ser_rx -> no rx_valid. Drive a frame of 8'hA5 with stop bit 0 -> rx_frame_err pulses once and rx_data is unchanged.
REQ-026 Assert rst during DATA of a TX frame -> ser_tx=1 and tx_busy=0 immediately; after release with tx_start=1, a new full frame is sent.
